// File: rtl/qeciphy_rx_checker.sv
// qeciphy_rx_checker
// Self-test checker for the QECIPHY RX AXI-Stream on the user clock. It regenerates
// the counter or PRBS sequence that the far-end generator sends and compares every
// accepted beat against it. It reports done/pass, the error count, the index of the
// first error, and abort, timeout and overrun conditions.
module qeciphy_rx_checker #(
  parameter string       MODE        = "PRBS",
  parameter int unsigned SEQ_LEN     = 2048,
  parameter logic [63:0] SEED        = 64'h1,
  parameter int unsigned WDOG_CYCLES = 65536
) (
  input  logic        ACLK,
  input  logic        ARSTn,
  input  logic        START,
  input  logic        LINK_READY,
  input  logic [63:0] S_TDATA,
  input  logic        S_TVALID,
  output logic        S_TREADY,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic        ABORTED,
  output logic        TIMEOUT,
  output logic        OVERRUN,
  output logic [15:0] ERR_CNT,
  output logic [31:0] BEAT_CNT,
  output logic [31:0] FIRST_ERR_IDX
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam bit          IS_PRBS   = (MODE == "PRBS");
  localparam logic [63:0] E0        = IS_PRBS ? SEED : 64'd0;
  localparam logic [31:0] LAST_IDX  = SEQ_LEN - 32'd1;
  localparam logic [31:0] WDOG_LAST = WDOG_CYCLES - 32'd1;

  // Parameter sanity checks at elaboration.
  if (!(MODE == "COUNTER" || MODE == "PRBS")) begin : g_bad_mode
    $error("qeciphy_rx_checker: MODE must be \"COUNTER\" or \"PRBS\"");
  end
  if (SEED == 64'd0) begin : g_bad_seed
    $error("qeciphy_rx_checker: SEED must be non-zero");
  end
  if (SEQ_LEN == 0) begin : g_bad_len
    $error("qeciphy_rx_checker: SEQ_LEN must be at least 1");
  end
  if (WDOG_CYCLES == 0) begin : g_bad_wdog
    $error("qeciphy_rx_checker: WDOG_CYCLES must be at least 1");
  end

  logic [1:0]  state;
  logic        tready;
  logic        done;
  logic        pass;
  logic        aborted;
  logic        timeout;
  logic        overrun;
  logic [15:0] err_cnt;
  logic [31:0] beat_cnt;
  logic [31:0] first_err;
  logic [63:0] expected;
  logic [31:0] wdog;

  logic        accept;
  logic        mismatch;
  logic        last_beat;
  logic        wdog_expired;
  logic [63:0] expected_next;

  // Decode the current beat against the expected word and compute the next expected word.
  always_comb begin
    accept       = S_TVALID & tready;
    mismatch     = (S_TDATA != expected);
    last_beat    = (beat_cnt == LAST_IDX);
    wdog_expired = (wdog == WDOG_LAST);
    if (IS_PRBS) begin
      expected_next = {expected[62:0], expected[63] ^ expected[62] ^ expected[60] ^ expected[59]};
    end else begin
      expected_next = expected + 64'd1;
    end
  end

  // Test sequencing, the comparison state and the result flags.
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state     <= ST_IDLE;
      tready    <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      aborted   <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
      err_cnt   <= '0;
      beat_cnt  <= '0;
      first_err <= '1;
      expected  <= E0;
      wdog      <= '0;
    end else begin
      tready <= 1'b1;
      case (state)
        ST_CHECK: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 32'd1;
            expected <= expected_next;
            wdog     <= '0;
            if (mismatch) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
              if (first_err == '1) first_err <= beat_cnt;
            end
            // The final beat takes priority over a simultaneous link drop.
            if (last_beat) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= (err_cnt == '0) && !mismatch;
            end else if (!LINK_READY) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              aborted <= 1'b1;
            end
          end else if (!LINK_READY) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (wdog_expired) begin
            state   <= ST_DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        default: begin
          if (START) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            aborted   <= 1'b0;
            timeout   <= 1'b0;
            overrun   <= 1'b0;
            err_cnt   <= '0;
            beat_cnt  <= '0;
            first_err <= '1;
            expected  <= E0;
            wdog      <= '0;
            if (LINK_READY) begin
              state <= ST_CHECK;
            end else begin
              state   <= ST_DONE;
              done    <= 1'b1;
              aborted <= 1'b1;
            end
          end
          if (accept) overrun <= 1'b1;
        end
      endcase
    end
  end

  assign S_TREADY      = tready;
  assign BUSY          = (state == ST_CHECK);
  assign DONE          = done;
  assign PASS          = pass;
  assign ABORTED       = aborted;
  assign TIMEOUT       = timeout;
  assign OVERRUN       = overrun;
  assign ERR_CNT       = err_cnt;
  assign BEAT_CNT      = beat_cnt;
  assign FIRST_ERR_IDX = first_err;

endmodule

// File: tb/tb_qeciphy_rx_checker.sv
// Testbench for qeciphy_rx_checker. It uses two instances: a COUNTER checker with
// SEQ_LEN=16 and WDOG_CYCLES=100, and a PRBS checker with SEED=1 and SEQ_LEN=2048.
// The stimulus pushes each expected test result into a queue. A separate monitor
// process pops that entry and compares it when DONE rises.
module tb_qeciphy_rx_checker;

  localparam logic [63:0] SEED_P = 64'h1;

  typedef struct {
    bit          pass;
    bit          aborted;
    bit          timeout;
    logic [15:0] err;
    logic [31:0] beats;
    logic [31:0] first;
    time         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        c_start = 0, c_lr = 1, c_valid = 0;
  logic [63:0] c_data = '0;
  logic        c_tready, c_busy, c_done, c_pass, c_aborted, c_timeout, c_overrun;
  logic [15:0] c_err;
  logic [31:0] c_beat, c_first;

  logic        p_start = 0, p_lr = 1, p_valid = 0;
  logic [63:0] p_data = '0;
  logic        p_tready, p_busy, p_done, p_pass, p_aborted, p_timeout, p_overrun;
  logic [15:0] p_err;
  logic [31:0] p_beat, p_first;

  int   checks = 0;
  int   failures = 0;
  int   out_cycles = 0;
  time  edge_t = 0;
  bit   c_trdrop = 0, p_trdrop = 0;
  exp_t q_c[$];
  exp_t q_p[$];

  always #5 clk = ~clk;

  qeciphy_rx_checker #(.MODE("COUNTER"), .SEQ_LEN(16), .SEED(64'h1), .WDOG_CYCLES(100)) u_cnt (
    .ACLK(clk), .ARSTn(rst_n), .START(c_start), .LINK_READY(c_lr),
    .S_TDATA(c_data), .S_TVALID(c_valid), .S_TREADY(c_tready),
    .BUSY(c_busy), .DONE(c_done), .PASS(c_pass), .ABORTED(c_aborted),
    .TIMEOUT(c_timeout), .OVERRUN(c_overrun), .ERR_CNT(c_err),
    .BEAT_CNT(c_beat), .FIRST_ERR_IDX(c_first)
  );

  qeciphy_rx_checker #(.MODE("PRBS"), .SEQ_LEN(2048), .SEED(SEED_P), .WDOG_CYCLES(65536)) u_prbs (
    .ACLK(clk), .ARSTn(rst_n), .START(p_start), .LINK_READY(p_lr),
    .S_TDATA(p_data), .S_TVALID(p_valid), .S_TREADY(p_tready),
    .BUSY(p_busy), .DONE(p_done), .PASS(p_pass), .ABORTED(p_aborted),
    .TIMEOUT(p_timeout), .OVERRUN(p_overrun), .ERR_CNT(p_err),
    .BEAT_CNT(p_beat), .FIRST_ERR_IDX(p_first)
  );

  function automatic logic [63:0] prbs_next(input logic [63:0] e);
    return {e[62:0], e[63] ^ e[62] ^ e[60] ^ e[59]};
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic mon_compare(input string tag, input exp_t e, input logic busy, input logic pass,
                             input logic ab, input logic to, input logic [15:0] err,
                             input logic [31:0] beat, input logic [31:0] first, input bit trdrop);
    cmp({tag, ".done_time"}, 64'($time) - 64'd5, 64'(e.t));
    cmp({tag, ".busy"}, 64'(busy), 64'd0);
    cmp({tag, ".pass"}, 64'(pass), 64'(e.pass));
    cmp({tag, ".aborted"}, 64'(ab), 64'(e.aborted));
    cmp({tag, ".timeout"}, 64'(to), 64'(e.timeout));
    cmp({tag, ".err_cnt"}, 64'(err), 64'(e.err));
    cmp({tag, ".beat_cnt"}, 64'(beat), 64'(e.beats));
    cmp({tag, ".first_err_idx"}, 64'(first), 64'(e.first));
    cmp({tag, ".tready_drop"}, 64'(trdrop), 64'd0);
  endtask

  initial forever begin
    @(posedge clk);
    out_cycles = rst_n ? out_cycles + 1 : 0;
  end

  // Monitor for the COUNTER instance.
  initial begin
    bit   prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_cycles > 0 && c_tready !== 1'b1) c_trdrop = 1;
        if (c_done === 1'b1 && !prev) begin
          if (q_c.size() == 0) begin
            checks++; failures++;
            $display("FAIL cnt.unexpected_done actual=1 expected=0");
          end else begin
            e = q_c.pop_front();
            mon_compare("cnt", e, c_busy, c_pass, c_aborted, c_timeout, c_err, c_beat, c_first, c_trdrop);
            c_trdrop = 0;
          end
        end
        prev = (c_done === 1'b1);
      end else prev = 0;
    end
  end

  // Monitor for the PRBS instance.
  initial begin
    bit   prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_cycles > 0 && p_tready !== 1'b1) p_trdrop = 1;
        if (p_done === 1'b1 && !prev) begin
          if (q_p.size() == 0) begin
            checks++; failures++;
            $display("FAIL prbs.unexpected_done actual=1 expected=0");
          end else begin
            e = q_p.pop_front();
            mon_compare("prbs", e, p_busy, p_pass, p_aborted, p_timeout, p_err, p_beat, p_first, p_trdrop);
            p_trdrop = 0;
          end
        end
        prev = (p_done === 1'b1);
      end else prev = 0;
    end
  end

  // One clock of stimulus: drive on the falling edge and release START/VALID after the rising edge.
  task automatic drive(input bit is_p, input logic st, input logic v, input logic [63:0] d, input logic lr);
    @(negedge clk);
    if (is_p) begin p_start = st; p_valid = v; p_data = d; p_lr = lr; end
    else      begin c_start = st; c_valid = v; c_data = d; c_lr = lr; end
    @(posedge clk);
    edge_t = $time;
    #1;
    if (is_p) begin p_start = 0; p_valid = 0; end
    else      begin c_start = 0; c_valid = 0; end
  endtask

  task automatic push(input bit is_p, input exp_t x);
    if (is_p) q_p.push_back(x); else q_c.push_back(x);
  endtask

  task automatic wait_drain(input bit is_p);
    int n;
    for (int i = 0; i < 400; i++) begin
      n = is_p ? q_p.size() : q_c.size();
      if (n == 0) break;
      @(posedge clk);
    end
    n = is_p ? q_p.size() : q_c.size();
    cmp(is_p ? "prbs.pending_results" : "cnt.pending_results", 64'(n), 64'd0);
    if (is_p) q_p.delete(); else q_c.delete();
  endtask

  function automatic exp_t mk(input bit pass, input bit ab, input bit to, input int unsigned err,
                              input int unsigned beats, input logic [31:0] first, input time t);
    exp_t x;
    x.pass = pass; x.aborted = ab; x.timeout = to; x.err = 16'(err);
    x.beats = 32'(beats); x.first = first; x.t = t;
    return x;
  endfunction

  // Complete test: START, then n beats with random gaps and corruptions.
  // Beats e1 and e2 are always corrupted: e1 gets a single-bit flip, e2 gets every bit flipped.
  task automatic full_run(input bit is_p, input int unsigned n, input int unsigned gap_max,
                          input int unsigned err_pct, input int e1, input int e2);
    logic [63:0]  e, m;
    int unsigned  errs;
    logic [31:0]  first;
    errs = 0; first = '1;
    e = is_p ? SEED_P : 64'd0;
    drive(is_p, 1, 0, '0, 1);
    for (int k = 0; k < int'(n); k++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) @(posedge clk);
      m = '0;
      if (k == e1) m = 64'h1;
      else if (k == e2) m = '1;
      else if ($urandom_range(99, 0) < err_pct) begin
        m = {$urandom, $urandom};
        if (m == '0) m = 64'h1;
      end
      if (m != '0) begin
        errs++;
        if (first == '1) first = 32'(k);
      end
      drive(is_p, 0, 1, e ^ m, 1);
      e = is_p ? prbs_next(e) : e + 64'd1;
    end
    push(is_p, mk(errs == 0, 0, 0, errs, n, first, edge_t));
    wait_drain(is_p);
  endtask

  task automatic check_reset_values(input string tag, input logic tr, input logic busy, input logic done,
                                    input logic pass, input logic ab, input logic to, input logic ov,
                                    input logic [15:0] err, input logic [31:0] beat, input logic [31:0] first);
    cmp({tag, ".tready"}, 64'(tr), 64'd0);
    cmp({tag, ".busy"}, 64'(busy), 64'd0);
    cmp({tag, ".done"}, 64'(done), 64'd0);
    cmp({tag, ".pass"}, 64'(pass), 64'd0);
    cmp({tag, ".aborted"}, 64'(ab), 64'd0);
    cmp({tag, ".timeout"}, 64'(to), 64'd0);
    cmp({tag, ".overrun"}, 64'(ov), 64'd0);
    cmp({tag, ".err_cnt"}, 64'(err), 64'd0);
    cmp({tag, ".beat_cnt"}, 64'(beat), 64'd0);
    cmp({tag, ".first_err_idx"}, 64'(first), 64'hFFFF_FFFF);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_time_limit actual=expired expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "time limit");
  end

  initial begin
    time t0;
    // Values while reset is held.
    #12;
    check_reset_values("rst_cnt", c_tready, c_busy, c_done, c_pass, c_aborted, c_timeout, c_overrun, c_err, c_beat, c_first);
    check_reset_values("rst_prbs", p_tready, p_busy, p_done, p_pass, p_aborted, p_timeout, p_overrun, p_err, p_beat, p_first);
    @(posedge clk); #2 rst_n = 1;
    repeat (2) @(posedge clk);
    #1;
    cmp("cnt.tready_after_reset", 64'(c_tready), 64'd1);
    cmp("prbs.tready_after_reset", 64'(p_tready), 64'd1);

    // Beat in IDLE sets OVERRUN and is not counted. START then clears OVERRUN.
    drive(0, 0, 1, 64'h5, 1);
    @(negedge clk);
    cmp("idle_beat.overrun", 64'(c_overrun), 64'd1);
    cmp("idle_beat.beat_cnt", 64'(c_beat), 64'd0);
    cmp("idle_beat.busy", 64'(c_busy), 64'd0);
    drive(0, 1, 0, '0, 1);
    @(negedge clk);
    cmp("start.overrun_cleared", 64'(c_overrun), 64'd0);
    cmp("start.busy", 64'(c_busy), 64'd1);
    // The START at the head of this run lands in CHECK and must be ignored.
    full_run(0, 16, 0, 0, -1, -1);

    // Beat in DONE: OVERRUN is set and the results are untouched.
    drive(0, 0, 1, 64'hAB, 1);
    @(negedge clk);
    cmp("done_beat.overrun", 64'(c_overrun), 64'd1);
    cmp("done_beat.beat_cnt", 64'(c_beat), 64'd16);
    cmp("done_beat.done", 64'(c_done), 64'd1);
    cmp("done_beat.pass", 64'(c_pass), 64'd1);

    // LINK_READY drops after 7 beats.
    drive(0, 1, 0, '0, 1);
    for (int k = 0; k < 7; k++) drive(0, 0, 1, 64'(k), 1);
    drive(0, 0, 0, '0, 0);
    push(0, mk(0, 1, 0, 0, 7, '1, edge_t));
    wait_drain(0);

    // LINK_READY drops on the same edge as the final beat, so completion wins.
    drive(0, 1, 0, '0, 1);
    for (int k = 0; k < 15; k++) drive(0, 0, 1, 64'(k), 1);
    drive(0, 0, 1, 64'd15, 0);
    push(0, mk(1, 0, 0, 0, 16, '1, edge_t));
    wait_drain(0);

    // Counter run with random gaps and random corruptions.
    full_run(0, 16, 3, 30, -1, -1);

    // Watchdog fires after 100 idle cycles.
    drive(0, 1, 0, '0, 1);
    t0 = edge_t;
    push(0, mk(0, 0, 1, 0, 0, '1, t0 + 1000));
    wait_drain(0);
    // A beat in idle cycle 99 restarts the count.
    drive(0, 1, 0, '0, 1);
    repeat (98) @(posedge clk);
    drive(0, 0, 1, 64'd0, 1);
    push(0, mk(0, 0, 1, 0, 1, '1, edge_t + 1000));
    wait_drain(0);
    // A beat on the expiry edge is counted, and no timeout occurs on that edge.
    drive(0, 1, 0, '0, 1);
    repeat (99) @(posedge clk);
    drive(0, 0, 1, 64'd0, 1);
    push(0, mk(0, 0, 1, 0, 1, '1, edge_t + 1000));
    wait_drain(0);

    // PRBS runs: fixed errors, random gaps with no errors, then random gaps with random errors.
    full_run(1, 2048, 0, 0, 5, 9);
    full_run(1, 2048, 7, 0, -1, -1);
    full_run(1, 2048, 3, 2, -1, -1);

    // Reset in the middle of CHECK.
    drive(0, 1, 0, '0, 1);
    for (int k = 0; k < 5; k++) drive(0, 0, 1, 64'(k), 1);
    #2 rst_n = 0;
    #1;
    check_reset_values("midrst_cnt", c_tready, c_busy, c_done, c_pass, c_aborted, c_timeout, c_overrun, c_err, c_beat, c_first);
    @(posedge clk); #2 rst_n = 1;

    // START while LINK_READY is low goes straight to DONE with ABORTED set.
    drive(0, 1, 0, '0, 0);
    push(0, mk(0, 1, 0, 0, 0, '1, edge_t));
    wait_drain(0);

    // A full run after the reset still passes.
    full_run(0, 16, 0, 0, -1, -1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
